// File: rtl/mem_responder_pkg.sv
// Shared widths and enumerations for the memory responder and its word array.
package mem_responder_pkg;

   localparam int RISCV_ADDR_WIDTH = 32;
   localparam int RISCV_WORD_WIDTH = 32;
   localparam int MEM_LANES        = 4;

   typedef enum logic {
      MEM_PORT_I = 1'b0,
      MEM_PORT_D = 1'b1
   } mem_port_e;

   typedef enum logic [1:0] {
      MRS_IDLE = 2'd0,
      MRS_WAIT = 2'd1,
      MRS_RESP = 2'd2
   } mem_resp_state_e;

   // Round-robin helper: the port that did not win last time.
   function automatic mem_port_e other_port(mem_port_e p);
      return (p == MEM_PORT_I) ? MEM_PORT_D : MEM_PORT_I;
   endfunction

endpackage

// File: rtl/mem_sram_1rw.sv
// Single-port word array: four byte-lane write enables, synchronous write,
// registered read.
module mem_sram_1rw
   import mem_responder_pkg::*;
#(
   parameter int    WORDS     = 4096,
   parameter int    AW        = 12,
   parameter string INIT_FILE = ""
) (
   input  logic                        clk,
   input  logic                        re,
   input  logic [MEM_LANES-1:0]        we,
   input  logic [AW-1:0]               addr,
   input  logic [RISCV_WORD_WIDTH-1:0] wdata,
   output logic [RISCV_WORD_WIDTH-1:0] rdata
);

   logic [RISCV_WORD_WIDTH-1:0] mem [WORDS];

   // Byte-lane write and registered read share the single port.
   always_ff @(posedge clk) begin
      for (int k = 0; k < MEM_LANES; k++) begin
         if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Two-port (instruction/data) valid/ready responder in front of one shared
// single-port word array, with round-robin arbitration and fixed wait states.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MRS_IDLE | sample both valids, grant one, latch its request
// MRS_WAIT | count down the wait states
// MRS_RESP | ready pulse to the granted port; array write commits here
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = RISCV_ADDR_WIDTH,
   parameter int                    WORD_WIDTH  = RISCV_WORD_WIDTH,
   parameter int                    MEM_WORDS   = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_CYCLES = 1,
   parameter string                 INIT_FILE   = ""
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  imem_valid_i,
   output logic                  imem_ready_o,
   input  logic [ADDR_WIDTH-1:0] imem_addr_i,
   input  logic [WORD_WIDTH-1:0] imem_wdata_i,
   input  logic [3:0]            imem_we_i,
   output logic [WORD_WIDTH-1:0] imem_rdata_o,
   input  logic                  dmem_valid_i,
   output logic                  dmem_ready_o,
   input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
   input  logic [WORD_WIDTH-1:0] dmem_wdata_i,
   input  logic [3:0]            dmem_we_i,
   output logic [WORD_WIDTH-1:0] dmem_rdata_o,
   output logic                  oor_o
);

   localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   mem_resp_state_e       state;
   logic [3:0]            cnt;
   mem_port_e             last_port, port_q, req_port, acc_port;
   logic [ADDR_WIDTH-1:0] addr_q, acc_addr, offset, idx;
   logic [WORD_WIDTH-1:0] wdata_q, sram_q, irdata_q, drdata_q;
   logic [3:0]            we_q, acc_we, sram_we;
   logic                  req_any, acc_oor, enter_resp, sram_re;
   logic                  rd_fresh_i, rd_fresh_d;

   // Arbitration and address decode. In IDLE the request is taken straight
   // from the winning port so a zero-wait read can start at the grant edge.
   always_comb begin
      req_any = imem_valid_i | dmem_valid_i;
      if (imem_valid_i && dmem_valid_i) req_port = other_port(last_port);
      else if (dmem_valid_i)            req_port = MEM_PORT_D;
      else                              req_port = MEM_PORT_I;

      if (state == MRS_IDLE) begin
         acc_port = req_port;
         acc_addr = (req_port == MEM_PORT_D) ? dmem_addr_i : imem_addr_i;
         acc_we   = (req_port == MEM_PORT_D) ? dmem_we_i : imem_we_i;
      end else begin
         acc_port = port_q;
         acc_addr = addr_q;
         acc_we   = we_q;
      end

      offset  = acc_addr - BASE_ADDR;
      idx     = offset >> 2;
      acc_oor = (acc_addr < BASE_ADDR) || (idx >= ADDR_WIDTH'(MEM_WORDS));

      enter_resp = ((state == MRS_IDLE) && req_any && (WAIT_CYCLES == 0)) ||
                   ((state == MRS_WAIT) && (cnt == 4'd1));
      // Read is issued on the edge into RESP so the registered array output
      // is valid during the ready cycle; writes commit on the edge out of RESP.
      sram_re = enter_resp && (acc_we == 4'b0) && !acc_oor;
      sram_we = ((state == MRS_RESP) && !acc_oor) ? we_q : 4'b0;
   end

   mem_sram_1rw #(
      .WORDS     (MEM_WORDS),
      .AW        (MW),
      .INIT_FILE (INIT_FILE)
   ) u_sram (
      .clk   (clk),
      .re    (sram_re),
      .we    (sram_we),
      .addr  (idx[MW-1:0]),
      .wdata (wdata_q),
      .rdata (sram_q)
   );

   // Sequencing FSM with registered ready/oor pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= MRS_IDLE;
         cnt          <= '0;
         last_port    <= MEM_PORT_I;
         port_q       <= MEM_PORT_I;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= '0;
         imem_ready_o <= 1'b0;
         dmem_ready_o <= 1'b0;
         oor_o        <= 1'b0;
         rd_fresh_i   <= 1'b0;
         rd_fresh_d   <= 1'b0;
      end else begin
         imem_ready_o <= 1'b0;
         dmem_ready_o <= 1'b0;
         oor_o        <= 1'b0;
         rd_fresh_i   <= 1'b0;
         rd_fresh_d   <= 1'b0;
         case (state)
            MRS_IDLE: begin
               if (req_any) begin
                  port_q    <= req_port;
                  last_port <= req_port;
                  addr_q    <= acc_addr;
                  we_q      <= acc_we;
                  wdata_q   <= (req_port == MEM_PORT_D) ? dmem_wdata_i : imem_wdata_i;
                  cnt       <= 4'(WAIT_CYCLES);
                  if (WAIT_CYCLES == 0) state <= MRS_RESP;
                  else                  state <= MRS_WAIT;
               end
            end
            MRS_WAIT: begin
               if (cnt == 4'd1) begin
                  state <= MRS_RESP;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            MRS_RESP: state <= MRS_IDLE;
            default:  state <= MRS_IDLE;
         endcase
         if (enter_resp) begin
            imem_ready_o <= (acc_port == MEM_PORT_I);
            dmem_ready_o <= (acc_port == MEM_PORT_D);
            oor_o        <= acc_oor;
            rd_fresh_i   <= (acc_port == MEM_PORT_I) && (acc_we == 4'b0);
            rd_fresh_d   <= (acc_port == MEM_PORT_D) && (acc_we == 4'b0);
         end
      end
   end

   // Per-port read data: during a read's ready cycle the array's output
   // register is shown (or zero when out of range); otherwise the held copy.
   // Both sources are flops, so nothing from the inputs reaches rdata.
   assign imem_rdata_o = rd_fresh_i ? (oor_o ? '0 : sram_q) : irdata_q;
   assign dmem_rdata_o = rd_fresh_d ? (oor_o ? '0 : sram_q) : drdata_q;

   // Capture each port's read result so it holds until that port's next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irdata_q <= '0;
         drdata_q <= '0;
      end else begin
         if (rd_fresh_i) irdata_q <= imem_rdata_o;
         if (rd_fresh_d) drdata_q <= dmem_rdata_o;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with different wait
// states and base addresses, a memory-semantics reference model, and a
// monitor that checks every ready pulse against queued expectations.
module tb_mem_responder;

   localparam int ND = 3;
   localparam int NW = 16;

   function automatic int wait_of(int d);
      case (d)
         0:       return 1;
         1:       return 0;
         default: return 3;
      endcase
   endfunction

   function automatic logic [31:0] base_of(int d);
      return (d == 1) ? 32'h0000_0100 : 32'h0000_0000;
   endfunction

   typedef struct packed {
      logic        dport;
      logic        oor;
      logic [31:0] rdata;
      logic [31:0] cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        iv [ND];
   logic        dv [ND];
   logic [31:0] ia [ND];
   logic [31:0] da [ND];
   logic [31:0] iw [ND];
   logic [31:0] dw [ND];
   logic [3:0]  ie [ND];
   logic [3:0]  de [ND];
   logic        ir [ND];
   logic        dr [ND];
   logic        oo [ND];
   logic [31:0] ird [ND];
   logic [31:0] drd [ND];

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   exp_t        exp_q [ND][$];
   logic [31:0] mdl [ND][NW];
   logic [31:0] last_rd [ND][2];

   for (genvar g = 0; g < ND; g++) begin : g_dut
      mem_responder #(
         .MEM_WORDS   (NW),
         .BASE_ADDR   (base_of(g)),
         .WAIT_CYCLES (wait_of(g))
      ) dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .imem_valid_i (iv[g]),
         .imem_ready_o (ir[g]),
         .imem_addr_i  (ia[g]),
         .imem_wdata_i (iw[g]),
         .imem_we_i    (ie[g]),
         .imem_rdata_o (ird[g]),
         .dmem_valid_i (dv[g]),
         .dmem_ready_o (dr[g]),
         .dmem_addr_i  (da[g]),
         .dmem_wdata_i (dw[g]),
         .dmem_we_i    (de[g]),
         .dmem_rdata_o (drd[g]),
         .oor_o        (oo[g])
      );
   end

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, int d, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s dut%0d: got %h expected %h", name, d, act, expv);
      end
   endtask

   // Reference model: memory semantics in completion order. Reads return the
   // word (0 if out of range); writes merge enabled bytes and leave the
   // port's previous read data visible.
   function automatic exp_t predict(int d, int p, logic [31:0] addr,
                                    logic [31:0] wdata, logic [3:0] we, int when);
      exp_t   e;
      longint off;
      int     idx;
      bit     out;
      off = longint'(addr) - longint'(base_of(d));
      out = (off < 0) || ((off / 4) >= NW);
      idx = out ? 0 : int'(off / 4);
      if (we == 4'b0) begin
         last_rd[d][p] = out ? 32'h0 : mdl[d][idx];
      end else if (!out) begin
         for (int k = 0; k < 4; k++)
            if (we[k]) mdl[d][idx][8*k +: 8] = wdata[8*k +: 8];
      end
      e.dport = (p == 1);
      e.oor   = out;
      e.rdata = last_rd[d][p];
      e.cyc   = 32'(when + 1 + wait_of(d));
      return e;
   endfunction

   task automatic check_resp(int d, int p, logic [31:0] rd, logic oor);
      exp_t e;
      if (exp_q[d].size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_ready dut%0d port%0d at cycle %0d", d, p, cyc);
         return;
      end
      e = exp_q[d].pop_front();
      chk("ready_port", d, 32'(p), {31'b0, e.dport});
      chk("rdata", d, rd, e.rdata);
      chk("oor", d, {31'b0, oor}, {31'b0, e.oor});
      chk("latency_cycle", d, 32'(cyc), e.cyc);
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (ir[d] || dr[d]) chk("one_ready_at_a_time", d, {31'b0, ir[d] && dr[d]}, 32'h0);
         if (oo[d] && !ir[d] && !dr[d]) chk("oor_without_ready", d, 32'h1, 32'h0);
         if (ir[d]) check_resp(d, 0, ird[d], oo[d]);
         if (dr[d]) check_resp(d, 1, drd[d], oo[d]);
      end
   end

   task automatic drive(int d, int p, logic v, logic [31:0] a, logic [31:0] w, logic [3:0] e);
      if (p == 0) begin iv[d] = v; ia[d] = a; iw[d] = w; ie[d] = e; end
      else        begin dv[d] = v; da[d] = a; dw[d] = w; de[d] = e; end
   endtask

   task automatic do_txn(int d, int p, logic [31:0] a, logic [31:0] w, logic [3:0] e);
      bit seen = 1'b0;
      exp_q[d].push_back(predict(d, p, a, w, e, cyc));
      drive(d, p, 1'b1, a, w, e);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = (p == 0) ? ir[d] : dr[d];
      end
      drive(d, p, 1'b0, 32'h0, 32'h0, 4'h0);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL txn_timeout dut%0d port%0d addr %h", d, p, a);
         exp_q[d].delete();
      end
      @(negedge clk);
   endtask

   // Valid held across ready pulses: both ports (alternating, data first
   // after reset) or the instruction port alone.
   task automatic held(int d, bit both, logic [31:0] ai, logic [31:0] ad, int n);
      int got;
      int per;
      int p;
      got = 0;
      per = wait_of(d) + 2;
      for (int k = 0; k < n; k++) begin
         p = (both && (k % 2 == 0)) ? 1 : 0;
         exp_q[d].push_back(predict(d, p, (p == 1) ? ad : ai, 32'h0, 4'h0, cyc + k * per));
      end
      drive(d, 0, 1'b1, ai, 32'h0, 4'h0);
      if (both) drive(d, 1, 1'b1, ad, 32'h0, 4'h0);
      for (int i = 0; i < n * per + 20 && got < n; i++) begin
         @(negedge clk);
         if (ir[d] || dr[d]) got++;
      end
      drive(d, 0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(d, 1, 1'b0, 32'h0, 32'h0, 4'h0);
      chk("held_ready_count", d, 32'(got), 32'(n));
      if (got != n) exp_q[d].delete();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      for (int d = 0; d < ND; d++) begin
         drive(d, 0, 1'b0, 32'h0, 32'h0, 4'h0);
         drive(d, 1, 1'b0, 32'h0, 32'h0, 4'h0);
         last_rd[d][0] = 32'h0;
         last_rd[d][1] = 32'h0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk("reset_imem_ready", d, {31'b0, ir[d]}, 32'h0);
         chk("reset_dmem_ready", d, {31'b0, dr[d]}, 32'h0);
         chk("reset_oor", d, {31'b0, oo[d]}, 32'h0);
         chk("reset_imem_rdata", d, ird[d], 32'h0);
         chk("reset_dmem_rdata", d, drd[d], 32'h0);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          p;
      int          r;
      logic [31:0] a;
      logic [3:0]  e;
      for (int d = 0; d < ND; d++) begin
         drive(d, 0, 1'b0, 32'h0, 32'h0, 4'h0);
         drive(d, 1, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      @(negedge clk);
      apply_reset();
      @(negedge clk);

      // Fill every word so the model and the array agree from here on.
      for (int d = 0; d < ND; d++)
         for (int w = 0; w < NW; w++)
            do_txn(d, w % 2, base_of(d) + 32'(4 * w), $urandom, 4'hF);

      // Directed cases on the one-wait-state instance.
      do_txn(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      do_txn(0, 0, 32'h10, 32'h0, 4'h0);
      do_txn(0, 1, 32'h14, 32'h1122_3344, 4'hF);
      do_txn(0, 1, 32'h14, 32'hAABB_CCDD, 4'b0101);
      do_txn(0, 0, 32'h14, 32'h0, 4'h0);
      do_txn(0, 0, 32'h40, 32'h0, 4'h0);
      do_txn(0, 1, 32'h40, 32'hFFFF_FFFF, 4'hF);
      do_txn(0, 0, 32'h0, 32'h0, 4'h0);
      do_txn(0, 0, 32'h3F, 32'h0, 4'h0);
      do_txn(1, 1, 32'hFC, 32'h0, 4'h0);
      do_txn(1, 0, 32'h13C, 32'h0, 4'h0);

      // Randomized traffic, including below-base and past-end addresses.
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < 40; i++) begin
            p = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7)      a = base_of(d) + $urandom_range(0, NW * 4 - 1);
            else if (r < 9) a = base_of(d) + 32'(NW * 4) + $urandom_range(0, 255);
            else            a = base_of(d) - 32'd4;
            e = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_txn(d, p, a, $urandom, e);
         end
      end

      // Contention straight out of reset: expect D, I, D, I.
      apply_reset();
      held(0, 1'b1, 32'h10, 32'h14, 4);

      // Zero wait states with valid held: ready every second cycle.
      held(1, 1'b0, 32'h104, 32'h0, 4);

      // Reset during the wait state of a write: nothing must be written.
      do_txn(0, 1, 32'h8, 32'h0, 4'hF);
      drive(0, 1, 1'b1, 32'h8, 32'h5555_AAAA, 4'hF);
      @(negedge clk);
      apply_reset();
      @(negedge clk);
      do_txn(0, 0, 32'h8, 32'h0, 4'h0);

      repeat (5) @(negedge clk);
      for (int d = 0; d < ND; d++)
         chk("pending_expectations", d, 32'(exp_q[d].size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
